// File: rtl/scmi_doorbell_if.sv
// scmi_doorbell_if
//   Groups the firmware-facing streams and the shared-memory write port of the
//   SCMI doorbell responder.
//
//   Handshake rule for both streams (msg_*, done_*): a transfer happens on a
//   rising clock edge where valid and ready are both 1. Once valid is raised,
//   valid and its payload hold steady until that transfer. Ready may change
//   freely. The memory port uses the same rule with req/gnt as the pair.
//   rvalid is a one-cycle write response that arrives after the grant.
//
//   Signals:
//     msg_valid / msg_ready / msg_ch    : pending-channel offer to firmware
//     done_valid / done_ready / done_ch : firmware completion report
//     mem_req / mem_gnt / mem_addr / mem_wdata / mem_we / mem_rvalid
//                                       : write-only shared-memory port
//   Modports:
//     slave  : responder side (drives offers, accepts completions, issues writes)
//     master : firmware/memory side
interface scmi_doorbell_if #(
    parameter int NUM_CH     = 8,
    parameter int ADDR_WIDTH = 32
);
    localparam int CH_W = $clog2(NUM_CH);

    logic                  msg_valid;
    logic                  msg_ready;
    logic [CH_W-1:0]       msg_ch;
    logic                  done_valid;
    logic                  done_ready;
    logic [CH_W-1:0]       done_ch;
    logic                  mem_req;
    logic                  mem_gnt;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic                  mem_we;
    logic                  mem_rvalid;

    modport slave (
        output msg_valid, msg_ch,
        input  msg_ready,
        input  done_valid, done_ch,
        output done_ready,
        output mem_req, mem_addr, mem_wdata, mem_we,
        input  mem_gnt, mem_rvalid
    );

    modport master (
        input  msg_valid, msg_ch,
        output msg_ready,
        output done_valid, done_ch,
        input  done_ready,
        input  mem_req, mem_addr, mem_wdata, mem_we,
        output mem_gnt, mem_rvalid
    );
endinterface

// File: rtl/scmi_doorbell_responder.sv
// scmi_doorbell_responder
//   Platform-side end of the SCMI doorbell channels. Doorbell rises are latched
//   per channel and offered round-robin to firmware. A completion report makes
//   the block write channel.status = 1 into the channel's shared-memory slot
//   and then pulse that channel's completion interrupt.
//
//   Ports:
//     clk_i, rst_ni : clock, synchronous active-low reset
//     doorbell_i    : agent doorbell levels (already synchronous to clk_i)
//     bus           : offer stream, completion stream and memory port (slave)
//     irq_o         : per-channel completion interrupt, IRQ_CYCLES long
//     overrun_o     : sticky per-channel doorbell overrun flags
//     err_o         : one-cycle pulse, completion for a channel not in service
//     fsm_state_o   : completion FSM state (IDLE=0, WR_REQ=1, WR_RSP=2, IRQ=3)
module scmi_doorbell_responder #(
    parameter int          NUM_CH        = 8,
    parameter int          ADDR_WIDTH    = 32,
    parameter logic [31:0] BASE_ADDR     = 32'h2000_0000,
    parameter logic [31:0] CH_STRIDE     = 32'h20,
    parameter logic [31:0] STATUS_OFFSET = 32'h4,
    parameter int          IRQ_CYCLES    = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NUM_CH-1:0] doorbell_i,
    scmi_doorbell_if.slave    bus,
    output logic [NUM_CH-1:0] irq_o,
    output logic [NUM_CH-1:0] overrun_o,
    output logic              err_o,
    output logic [1:0]        fsm_state_o
);
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(IRQ_CYCLES + 1);
    localparam logic [ADDR_WIDTH-1:0] BASE_A   = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] STRIDE_A = ADDR_WIDTH'(CH_STRIDE);
    localparam logic [ADDR_WIDTH-1:0] OFFSET_A = ADDR_WIDTH'(STATUS_OFFSET);

    typedef enum logic [1:0] {IDLE, WR_REQ, WR_RSP, IRQ} state_t;

    state_t            state, state_n;
    logic [NUM_CH-1:0] db_q, pending, in_service, overrun;
    logic [NUM_CH-1:0] rise, eligible, hs_mask, done_mask;
    logic [CH_W-1:0]   ptr, msg_ch_q, cur_ch, pick_ch, cand;
    logic              pick_found;
    logic              msg_valid_q, done_ready_q, err_q;
    logic              hs, done_fire, done_hit;
    logic [CNT_W-1:0]  irq_cnt;

    logic                  mem_req, mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic [NUM_CH-1:0]     irq;

    assign rise      = doorbell_i & ~db_q;
    assign eligible  = pending & ~in_service;
    assign hs        = msg_valid_q & bus.msg_ready;
    assign hs_mask   = hs ? (NUM_CH'(1) << msg_ch_q) : '0;
    assign done_fire = (state == IDLE) & done_ready_q & bus.done_valid;
    assign done_hit  = done_fire & in_service[bus.done_ch];
    assign done_mask = done_hit ? (NUM_CH'(1) << bus.done_ch) : '0;

    // First eligible channel at or above the pointer, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_ch    = '0;
        cand       = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand = CH_W'((int'(ptr) + k) % NUM_CH);
            if (!pick_found && eligible[cand]) begin
                pick_found = 1'b1;
                pick_ch    = cand;
            end
        end
    end

    // Doorbell latching and offer stream; runs independently of the FSM.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            db_q         <= '0;
            pending      <= '0;
            in_service   <= '0;
            overrun      <= '0;
            ptr          <= '0;
            msg_valid_q  <= 1'b0;
            msg_ch_q     <= '0;
            done_ready_q <= 1'b0;
            err_q        <= 1'b0;
            cur_ch       <= '0;
            irq_cnt      <= '0;
        end else begin
            db_q       <= doorbell_i;
            // A rise in the handshake cycle re-arms the channel.
            pending    <= (pending & ~hs_mask) | rise;
            in_service <= (in_service | hs_mask) & ~done_mask;
            // A fresh overrun wins over the clear from a same-cycle completion.
            overrun    <= (overrun & ~done_mask) | (rise & (pending | in_service));
            if (msg_valid_q) begin
                if (hs) begin
                    msg_valid_q <= 1'b0;
                    ptr <= (msg_ch_q == CH_W'(NUM_CH - 1)) ? '0 : msg_ch_q + CH_W'(1);
                end
            end else if (pick_found) begin
                msg_valid_q <= 1'b1;
                msg_ch_q    <= pick_ch;
            end
            // Registered so it reads 0 straight out of reset.
            done_ready_q <= (state_n == IDLE);
            err_q        <= done_fire & ~in_service[bus.done_ch];
            if (done_hit) cur_ch <= bus.done_ch;
            irq_cnt <= (state == IRQ) ? irq_cnt + CNT_W'(1) : '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n   = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        mem_addr  = '0;
        irq       = '0;
        case (state)
            IDLE: begin
                if (done_hit) state_n = WR_REQ;
            end
            WR_REQ: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_wdata = 32'h1;
                mem_addr  = BASE_A + STRIDE_A * ADDR_WIDTH'(cur_ch) + OFFSET_A;
                if (bus.mem_gnt) state_n = WR_RSP;
            end
            WR_RSP: begin
                if (bus.mem_rvalid) state_n = IRQ;
            end
            IRQ: begin
                irq = NUM_CH'(1) << cur_ch;
                if (irq_cnt == CNT_W'(IRQ_CYCLES - 1)) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.msg_valid  = msg_valid_q;
    assign bus.msg_ch     = msg_ch_q;
    assign bus.done_ready = done_ready_q;
    assign bus.mem_req    = mem_req;
    assign bus.mem_we     = mem_we;
    assign bus.mem_wdata  = mem_wdata;
    assign bus.mem_addr   = mem_addr;
    assign irq_o          = irq;
    assign overrun_o      = overrun;
    assign err_o          = err_q;
    assign fsm_state_o    = state;
endmodule

// File: tb/tb_scmi_doorbell_responder.sv
module tb_scmi_doorbell_responder;
    localparam int NCH = 8;
    localparam int IRQ_CYCLES = 4;
    localparam logic [31:0] BASE = 32'h2000_0000;
    localparam logic [31:0] STRIDE = 32'h20;
    localparam logic [31:0] OFF = 32'h4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    logic [NCH-1:0] doorbell = '0;
    logic [NCH-1:0] irq, overrun;
    logic           err;
    logic [1:0]     fsm_state;

    scmi_doorbell_if #(.NUM_CH(NCH), .ADDR_WIDTH(32)) bus ();

    scmi_doorbell_responder #(
        .NUM_CH(NCH), .ADDR_WIDTH(32), .BASE_ADDR(BASE), .CH_STRIDE(STRIDE),
        .STATUS_OFFSET(OFF), .IRQ_CYCLES(IRQ_CYCLES)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .doorbell_i(doorbell), .bus(bus),
        .irq_o(irq), .overrun_o(overrun), .err_o(err), .fsm_state_o(fsm_state)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Channel bookkeeping as plain bit vectors; completion as a phase number
    // (0 idle, 1 write request, 2 wait response, 3 interrupt) with a countdown.
    bit [NCH-1:0] m_prev, m_pend, m_svc, m_ovr, m_rise, np, ns, no;
    bit  m_live = 0, m_valid = 0, m_err = 0, m_hs, m_ready, m_acc, m_hit;
    int  m_ptr, m_ch, m_phase, m_cur, m_left, m_since, m_dch;

    always @(posedge clk) begin
        if (!rst_ni) begin
            m_live = 1; m_prev = '0; m_pend = '0; m_svc = '0; m_ovr = '0;
            m_valid = 0; m_ch = 0; m_ptr = 0; m_err = 0;
            m_phase = 0; m_cur = 0; m_left = 0; m_since = 0;
        end else begin
            m_rise  = doorbell & ~m_prev;
            m_hs    = m_valid && bus.msg_ready;
            m_ready = (m_phase == 0) && (m_since > 0);
            m_acc   = m_ready && bus.done_valid;
            m_dch   = int'(bus.done_ch);
            m_hit   = m_acc && m_svc[m_dch];
            m_err   = m_acc && !m_svc[m_dch];
            np = m_pend; ns = m_svc; no = m_ovr;
            if (m_hs) begin np[m_ch] = 0; ns[m_ch] = 1; end
            if (m_hit) begin ns[m_dch] = 0; no[m_dch] = 0; end
            for (int i = 0; i < NCH; i++)
                if (m_rise[i]) begin
                    if (m_pend[i] || m_svc[i]) no[i] = 1;
                    np[i] = 1;
                end
            if (m_valid) begin
                if (m_hs) begin m_valid = 0; m_ptr = (m_ch + 1) % NCH; end
            end else begin
                for (int k = 0; k < NCH; k++) begin
                    int c;
                    c = (m_ptr + k) % NCH;
                    if (m_pend[c] && !m_svc[c]) begin m_valid = 1; m_ch = c; break; end
                end
            end
            case (m_phase)
                0: if (m_hit) begin m_phase = 1; m_cur = m_dch; end
                1: if (bus.mem_gnt) m_phase = 2;
                2: if (bus.mem_rvalid) begin m_phase = 3; m_left = IRQ_CYCLES; end
                default: begin m_left--; if (m_left == 0) m_phase = 0; end
            endcase
            m_pend = np; m_svc = ns; m_ovr = no;
            m_prev = doorbell;
            m_since++;
        end
    end

    // ---------------- scoreboard / compare process ----------------
    logic [2:0] exp_q[$];   // expected handshake order, filled by tests
    logic [2:0] hs_q[$];    // observed handshake order
    int irq_hi = 0;
    logic [NCH-1:0] irq_or = '0;

    always @(negedge clk) begin
        if (m_live) begin
            chk("msg_valid", bus.msg_valid, m_valid);
            if (m_valid) chk("msg_ch", bus.msg_ch, m_ch);
            chk("done_ready", bus.done_ready, (m_phase == 0) && (m_since > 0));
            chk("mem_req", bus.mem_req, m_phase == 1);
            chk("mem_we", bus.mem_we, m_phase == 1);
            chk("mem_wdata", bus.mem_wdata, (m_phase == 1) ? 32'h1 : 32'h0);
            chk("mem_addr", bus.mem_addr,
                (m_phase == 1) ? BASE + STRIDE * 32'(m_cur) + OFF : 32'h0);
            chk("irq", irq, (m_phase == 3) ? (NCH'(1) << m_cur) : '0);
            chk("overrun", overrun, m_ovr);
            chk("err", err, m_err);
        end
        if (rst_ni && bus.msg_valid && bus.msg_ready) hs_q.push_back(bus.msg_ch);
        if (irq != '0) begin irq_hi++; irq_or |= irq; end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_done(input int ch);
        int budget = 40;
        while (!bus.done_ready && budget > 0) begin step(1); budget--; end
        if (budget == 0) chk("done_ready_wait", 0, 1);
        bus.done_valid = 1'b1;
        bus.done_ch = 3'(ch);
        step(1);
        bus.done_valid = 1'b0;
    endtask

    task automatic mem_write(input int gnt_delay);
        int budget = 40;
        while (!bus.mem_req && budget > 0) begin step(1); budget--; end
        if (budget == 0) chk("mem_req_wait", 0, 1);
        step(gnt_delay);
        bus.mem_gnt = 1'b1;
        step(1);
        bus.mem_gnt = 1'b0;
        bus.mem_rvalid = 1'b1;
        step(1);
        bus.mem_rvalid = 1'b0;
    endtask

    task automatic check_order(input string name);
        chk({name, "_count"}, hs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < hs_q.size(); i++)
            chk(name, hs_q[i], exp_q[i]);
        hs_q.delete();
        exp_q.delete();
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        bus.msg_ready = 0; bus.done_valid = 0; bus.done_ch = '0;
        bus.mem_gnt = 0; bus.mem_rvalid = 0;
        step(3);
        chk("rst_msg_valid", bus.msg_valid, 0);
        chk("rst_msg_ch", bus.msg_ch, 0);
        chk("rst_done_ready", bus.done_ready, 0);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_irq", irq, 0);
        chk("rst_err_ovr", {err, overrun}, 0);
        rst_ni = 1'b1;
        step(2);

        // Single doorbell held 1us, firmware always ready.
        bus.msg_ready = 1'b1;
        doorbell = 8'h01;
        step(2);
        chk("single_valid_t2", bus.msg_valid, 1);
        chk("single_ch_t2", bus.msg_ch, 0);
        step(98);
        doorbell = 8'h00;
        exp_q.push_back(3'd0);
        check_order("single_hs");
        bus.msg_ready = 1'b0;

        // Completion of channel 0.
        do_done(0);
        chk("c0_mem_req", bus.mem_req, 1);
        chk("c0_addr", bus.mem_addr, 32'h2000_0004);
        chk("c0_wdata", bus.mem_wdata, 32'h1);
        chk("c0_done_ready", bus.done_ready, 0);
        irq_hi = 0; irq_or = '0;
        mem_write(2);
        step(8);
        chk("c0_irq_len", irq_hi, 4);
        chk("c0_irq_bits", irq_or, 8'h01);

        // Back-to-back rises on 0, 1, 2 with firmware stalled.
        doorbell = 8'h01; step(1);
        doorbell = 8'h02; step(1);
        doorbell = 8'h04; step(1);
        doorbell = 8'h00; step(4);
        bus.msg_ready = 1'b1;
        step(8);
        bus.msg_ready = 1'b0;
        exp_q.push_back(3'd0); exp_q.push_back(3'd1); exp_q.push_back(3'd2);
        check_order("b2b_order");
        do_done(2);
        chk("c2_addr", bus.mem_addr, 32'h2000_0044);
        mem_write(0);
        do_done(0); mem_write(1);
        do_done(1); mem_write(0);
        step(6);

        // Round-robin: move pointer to 2 via channel 1, then 1 and 5 together.
        doorbell = 8'h02; step(1);
        doorbell = 8'h00; step(3);
        bus.msg_ready = 1'b1; step(1);
        bus.msg_ready = 1'b0;
        exp_q.push_back(3'd1);
        check_order("rr_prep");
        do_done(1); mem_write(0); step(6);
        doorbell = 8'h22; step(1);
        doorbell = 8'h00; step(4);
        bus.msg_ready = 1'b1; step(6);
        bus.msg_ready = 1'b0;
        exp_q.push_back(3'd5); exp_q.push_back(3'd1);
        check_order("rr_order");
        do_done(5); mem_write(0);
        do_done(1); mem_write(0);
        step(6);

        // Overrun on channel 3, cleared by its completion; error on idle channel 6.
        doorbell = 8'h08; step(1);
        doorbell = 8'h00; step(3);
        bus.msg_ready = 1'b1; step(1);
        bus.msg_ready = 1'b0;
        step(1);
        chk("ovr_before", overrun, 8'h00);
        doorbell = 8'h08; step(1);
        doorbell = 8'h00; step(1);
        chk("ovr_set", overrun, 8'h08);
        do_done(3);
        chk("ovr_clear", overrun, 8'h00);
        mem_write(0); step(6);
        do_done(6);
        chk("err_pulse", err, 1);
        chk("err_no_mem", bus.mem_req, 0);
        step(1);
        chk("err_one_cycle", err, 0);
        hs_q.delete();

        // Reset while the write request waits for a grant.
        bus.msg_ready = 1'b1; step(2);
        bus.msg_ready = 1'b0;
        doorbell = 8'h10; step(1);
        doorbell = 8'h00;
        do_done(3);
        step(2);
        chk("pre_rst_req", bus.mem_req, 1);
        rst_ni = 1'b0;
        step(1);
        chk("rst_mid_req", bus.mem_req, 0);
        chk("rst_mid_irq", irq, 0);
        chk("rst_mid_valid", bus.msg_valid, 0);
        chk("rst_mid_flags", {err, overrun}, 0);
        rst_ni = 1'b1;
        step(12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
